wb_arbiter: RTL
===============

// Module: wb_arbiter
// PURPOSE
//  Writer side of the register file: merges pipeline writeback (primary, never stalls) and
//  long-latency results (secondary, valid/ready) onto the single regfile write port
//  (enable/wreg/wdata). Secondary results wait in a small queue.
//  Tracks pending writes for two read addresses; forwards their data or raises stall.
// PARAMETERS
//  WIDTH   32  data width, matches regfile WIDTH
//  DEPTH   32  register count; ADDR = $clog2(DEPTH)
//  QDEPTH  4   secondary queue entries, power of 2, >= 2
// PORTS
//  clk       in   1      clock, all state on posedge
//  reset     in   1      asynchronous, active-low reset
//  p_valid   in   1      primary writeback request, always accepted
//  p_reg     in   ADDR   primary destination register
//  p_data    in   WIDTH  primary data
//  s_valid   in   1      secondary request
//  s_ready   out  1      queue can accept; transfer when s_valid & s_ready
//  s_reg     in   ADDR   secondary destination register
//  s_data    in   WIDTH  secondary data
//  rf_enable out  1      to regfile enable (registered)
//  rf_wreg   out  ADDR   to regfile wreg (registered)
//  rf_wdata  out  WIDTH  to regfile wdata (registered)
//  q_reg1    in   ADDR   lookup address, driven with regfile rreg1
//  q_reg2    in   ADDR   lookup address, driven with regfile rreg2
//  fwd_hit1  out  1      q_reg1 has a pending write
//  fwd_hit2  out  1      q_reg2 has a pending write
//  fwd_data1 out  WIDTH  newest pending data for q_reg1
//  fwd_data2 out  WIDTH  newest pending data for q_reg2
//  stall     out  1      reader must hold this cycle
//  q_count   out  $clog2(QDEPTH)+1  queue occupancy, killed entries included
// BEHAVIOUR
//  - Reset (async assert, sync release): queue empty, all entry valids 0, rf_enable=0,
//    rf_wreg=0, rf_wdata=0, q_count=0; s_ready=0 while reset is low. Queued writes are discarded.
//  - Output stage, per cycle: if p_valid & p_reg!=0, load rf_* with p next cycle (latency 1);
//    else if queue non-empty, pop head: rf_enable=head.valid, rf_wreg/rf_wdata=head;
//    else rf_enable=0 (rf_wreg/rf_wdata hold).
//  - p_reg==0 counts as no request (queue may pop). Pushes with s_reg==0 complete the
//    handshake but are not stored.
//  - s_ready = (q_count < QDEPTH); a pop in the same cycle does not raise s_ready.
//    Push and pop in the same cycle: q_count is unchanged. Pointers wrap modulo QDEPTH.
//  - Minimum secondary latency: push in cycle N, pop in N+1, rf_enable in N+2.
//  - WAW kill: an accepted primary write clears the valid bit of every queued entry with
//    the same reg. The same applies to a same-cycle secondary push to that reg, which is
//    stored invalid. A killed entry still occupies a slot; its pop produces rf_enable=0.
//  - Hit k: q_regk!=0 and q_regk matches a valid queue entry or (rf_enable & rf_wreg).
//    The rf stage counts because the regfile writes it only at the next edge.
//    Data priority: youngest valid queue entry (nearest tail), then the rf stage.
//  - fwd_hit/fwd_data/stall are combinational from current state and q_reg only.
//    Same-cycle p/s inputs are not visible.
// CONFIGURATION
//  WB_FORWARD_EN defined: fwd_data1/2 carry the newest pending data; stall=0.
//  WB_FORWARD_EN undefined: fwd_data1/2 tied to 0; stall = fwd_hit1 | fwd_hit2.
//  fwd_hit1/2 are computed in both builds.
// STRUCTURE
//  defines.v: WB_FORWARD_EN switch and a clog2-based ADDR helper, shared with the regfile.
//  Sub-module wb_queue: circular FIFO with per-entry valid bit, reg-match kill,
//  and two youngest-match lookup ports. wb_arbiter holds the priority mux and rf output registers.
// TESTING
//  1 Reset low mid-traffic, 3 entries queued -> all rf_* = 0, q_count=0, s_ready=0;
//    after release, s_ready=1 and no queued write ever appears.
//  2 p_valid, p_reg=5, p_data=32'hA5A5A5A5 -> next cycle rf_enable=1, rf_wreg=5,
//    rf_wdata=32'hA5A5A5A5.
//  3 4 pushes (regs 1..4) with p_valid held high -> s_ready=0 at q_count=4.
//    Drop p_valid -> regs 1,2,3,4 written in order on 4 consecutive cycles.
//  4 Queue holds reg 7=32'h11; p writes reg 7=32'h22 -> reg 7 written 32'h22;
//    the later pop of the reg-7 entry gives rf_enable=0.
//  5 Queue holds reg 9=1 then reg 9=2, q_reg1=9 -> fwd_hit1=1; with WB_FORWARD_EN
//    fwd_data1=2, stall=0; without WB_FORWARD_EN stall=1.
//  6 s_valid with s_reg=0 while q_count=1 -> handshake completes, q_count stays 1,
//    no rf write for reg 0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
package wb_arbiter_pkg;

  localparam int unsigned WB_WIDTH  = 32;
  localparam int unsigned WB_DEPTH  = 32;
  localparam int unsigned WB_QDEPTH = 4;

  // Source selected for the registered regfile write port
  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_PRIMARY = 2'd1,
    SRC_QUEUE   = 2'd2
  } wb_src_e;

  // True when n is a power of two (queue pointers wrap by overflow)
  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/wb_arbiter_queue.sv
// Secondary write queue: circular FIFO with per-entry valid bit, register-match
// kill, and two youngest-match lookup ports.
module wb_arbiter_queue
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = WB_WIDTH,
  parameter int unsigned ADDR   = 5,
  parameter int unsigned QDEPTH = WB_QDEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_push,
  input  logic [ADDR-1:0]           i_push_reg,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic                      i_pop,
  input  logic                      i_kill,
  input  logic [ADDR-1:0]           i_kill_reg,
  output logic                      o_head_valid,
  output logic [ADDR-1:0]           o_head_reg,
  output logic [WIDTH-1:0]          o_head_data,
  output logic [$clog2(QDEPTH):0]   o_count,
  input  logic [ADDR-1:0]           i_look_reg1,
  input  logic [ADDR-1:0]           i_look_reg2,
  output logic                      o_look_hit1,
  output logic [WIDTH-1:0]          o_look_data1,
  output logic                      o_look_hit2,
  output logic [WIDTH-1:0]          o_look_data2
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [QDEPTH-1:0] r_valid;
  logic [ADDR-1:0]   r_reg  [QDEPTH];
  logic [WIDTH-1:0]  r_data [QDEPTH];

  logic [QDEPTH-1:0] w_valid_nxt;
  logic              w_push_live;
  logic [PW-1:0]     w_age_idx [QDEPTH];

  // A push to the register the primary is writing this cycle is already stale
  assign w_push_live = i_push & ~(i_kill & (i_push_reg == i_kill_reg));

  // Next valid bits: kill matches, retire head on pop, set tail on push
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if (i_kill && (r_reg[i] == i_kill_reg)) begin
        w_valid_nxt[i] = 1'b0;
      end
    end
    if (i_pop) begin
      w_valid_nxt[r_head] = 1'b0;
    end
    if (i_push) begin
      w_valid_nxt[r_tail] = w_push_live;
    end
  end

  // Queue storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      if (i_push) begin
        r_reg[r_tail]  <= i_push_reg;
        r_data[r_tail] <= i_push_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (i_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Slot index ordered by age, oldest first
  always_comb begin
    for (int i = 0; i < int'(QDEPTH); i++) begin
      w_age_idx[i] = r_head + PW'(i);
    end
  end

  // Youngest valid match wins: scan oldest to youngest, later hits override
  always_comb begin
    o_look_hit1  = 1'b0;
    o_look_data1 = '0;
    o_look_hit2  = 1'b0;
    o_look_data2 = '0;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      if ((CW'(i) < r_count) && r_valid[w_age_idx[i]]) begin
        if (r_reg[w_age_idx[i]] == i_look_reg1) begin
          o_look_hit1  = 1'b1;
          o_look_data1 = r_data[w_age_idx[i]];
        end
        if (r_reg[w_age_idx[i]] == i_look_reg2) begin
          o_look_hit2  = 1'b1;
          o_look_data2 = r_data[w_age_idx[i]];
        end
      end
    end
  end

  assign o_head_valid = r_valid[r_head];
  assign o_head_reg   = r_reg[r_head];
  assign o_head_data  = r_data[r_head];
  assign o_count      = r_count;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write arbiter: primary writeback has absolute priority, secondary
// results drain from a small queue, pending writes are tracked for two readers.
// Build option: WB_FORWARD_EN forwards pending data instead of stalling.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH  = WB_WIDTH,
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned QDEPTH = WB_QDEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_valid,
  input  logic [$clog2(DEPTH)-1:0] p_reg,
  input  logic [WIDTH-1:0]         p_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [$clog2(DEPTH)-1:0] s_reg,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     rf_enable,
  output logic [$clog2(DEPTH)-1:0] rf_wreg,
  output logic [WIDTH-1:0]         rf_wdata,
  input  logic [$clog2(DEPTH)-1:0] q_reg1,
  input  logic [$clog2(DEPTH)-1:0] q_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [WIDTH-1:0]         fwd_data1,
  output logic [WIDTH-1:0]         fwd_data2,
  output logic                     stall,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int unsigned ADDR = $clog2(DEPTH);
  localparam int unsigned CW   = $clog2(QDEPTH) + 1;
  localparam bit          QDEPTH_OK = is_pow2(QDEPTH) && (QDEPTH >= 2);

  logic              w_p_acc;
  logic              w_not_full;
  logic              w_push;
  logic              w_pop;
  wb_src_e           w_src;

  logic              w_head_valid;
  logic [ADDR-1:0]   w_head_reg;
  logic [WIDTH-1:0]  w_head_data;
  logic [CW-1:0]     w_count;
  logic              w_qhit1;
  logic              w_qhit2;
  logic [WIDTH-1:0]  w_qdata1;
  logic [WIDTH-1:0]  w_qdata2;
  logic              w_hit1;
  logic              w_hit2;
  logic [WIDTH-1:0]  w_data1;
  logic [WIDTH-1:0]  w_data2;

  logic              r_rf_enable;
  logic [ADDR-1:0]   r_rf_wreg;
  logic [WIDTH-1:0]  r_rf_wdata;

  // Register 0 is never written, so a primary to r0 is no request at all
  assign w_p_acc    = p_valid & (p_reg != '0);
  assign w_not_full = (w_count < CW'(QDEPTH)) & QDEPTH_OK;
  assign w_push     = s_valid & w_not_full & (s_reg != '0);
  assign w_pop      = ~w_p_acc & (w_count != '0);

  // Handshake is refused while reset is held
  assign s_ready = reset & w_not_full;
  assign q_count = w_count;

  wb_arbiter_queue #(
    .WIDTH  (WIDTH),
    .ADDR   (ADDR),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_reg   (s_reg),
    .i_push_data  (s_data),
    .i_pop        (w_pop),
    .i_kill       (w_p_acc),
    .i_kill_reg   (p_reg),
    .o_head_valid (w_head_valid),
    .o_head_reg   (w_head_reg),
    .o_head_data  (w_head_data),
    .o_count      (w_count),
    .i_look_reg1  (q_reg1),
    .i_look_reg2  (q_reg2),
    .o_look_hit1  (w_qhit1),
    .o_look_data1 (w_qdata1),
    .o_look_hit2  (w_qhit2),
    .o_look_data2 (w_qdata2)
  );

  // Write-port source select: primary beats the queue
  always_comb begin
    w_src = SRC_NONE;
    if (w_p_acc) begin
      w_src = SRC_PRIMARY;
    end else if (w_pop) begin
      w_src = SRC_QUEUE;
    end
  end

  // Registered regfile write port; address/data hold when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rf_enable <= 1'b0;
      r_rf_wreg   <= '0;
      r_rf_wdata  <= '0;
    end else begin
      case (w_src)
        SRC_PRIMARY: begin
          r_rf_enable <= 1'b1;
          r_rf_wreg   <= p_reg;
          r_rf_wdata  <= p_data;
        end
        SRC_QUEUE: begin
          r_rf_enable <= w_head_valid;
          r_rf_wreg   <= w_head_reg;
          r_rf_wdata  <= w_head_data;
        end
        default: begin
          r_rf_enable <= 1'b0;
        end
      endcase
    end
  end

  assign rf_enable = r_rf_enable;
  assign rf_wreg   = r_rf_wreg;
  assign rf_wdata  = r_rf_wdata;

  // Pending-write lookup: queue entries are newer than the rf stage
  always_comb begin
    w_hit1  = (q_reg1 != '0) & (w_qhit1 | (r_rf_enable & (r_rf_wreg == q_reg1)));
    w_hit2  = (q_reg2 != '0) & (w_qhit2 | (r_rf_enable & (r_rf_wreg == q_reg2)));
    w_data1 = '0;
    w_data2 = '0;
    if (w_hit1) begin
      w_data1 = w_qhit1 ? w_qdata1 : r_rf_wdata;
    end
    if (w_hit2) begin
      w_data2 = w_qhit2 ? w_qdata2 : r_rf_wdata;
    end
  end

  assign fwd_hit1 = w_hit1;
  assign fwd_hit2 = w_hit2;

`ifdef WB_FORWARD_EN
  // Readers take the pending value directly and never wait
  assign fwd_data1 = w_data1;
  assign fwd_data2 = w_data2;
  assign stall     = 1'b0;
`else
  // Readers wait until the pending write has reached the regfile
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_data1, w_data2};
  assign fwd_data1    = '0;
  assign fwd_data2    = '0;
  assign stall        = w_hit1 | w_hit2;
`endif

endmodule
